// File: rtl/aes_decrypt_iter_pkg.sv
// Shared AES definitions for the iterative inverse cipher: block geometry, FSM encoding,
// GF(2^8) helpers, forward/inverse S-box functions and the Rcon table.
package aes_pkg;

   localparam int Nb = 4;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      ROUND,
      DONE
   } fsmState_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (0 maps to 0), so the S-boxes need no lookup tables.
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a6   = gf_mul(a3, a3);
      a12  = gf_mul(a6, a6);
      a15  = gf_mul(a12, a3);
      a30  = gf_mul(a15, a15);
      a60  = gf_mul(a30, a30);
      a120 = gf_mul(a60, a60);
      a240 = gf_mul(a120, a120);
      a252 = gf_mul(a240, a12);
      return gf_mul(a252, a2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gfInv(a);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
               ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] y;
      y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gfInv(y);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] v;
      case (idx)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Ciphertext/key input handshake and plaintext output handshake of the AES decryptor.
interface aes_decrypt_iter_if #(
   parameter int Nk = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [127:0]      data_in;
   logic [Nk*32-1:0]  key;
   logic              new_key;
   logic              out_valid;
   logic              out_ready;
   logic [127:0]      data_out;

   modport master (
      output in_valid, data_in, key, new_key, out_ready,
      input  in_ready, out_valid, data_out
   );

   modport slave (
      input  in_valid, data_in, key, new_key, out_ready,
      output in_ready, out_valid, data_out
   );
endinterface

// File: rtl/aes_decrypt_iter_inv_round.sv
// One combinational AES inverse round; the first round is AddRoundKey only and the
// last round skips InvMixColumns.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_roundKey,
   input  logic         i_isFirst,
   input  logic         i_isLast,
   output logic [127:0] o_nextState
);

   logic [7:0] w_in    [16];
   logic [7:0] w_shift [16];
   logic [7:0] w_keyed [16];
   logic [7:0] w_mix   [16];
   logic [127:0] w_keyedFlat;
   logic [127:0] w_mixFlat;

   // Bytes are column-major: byte 4c+r is row r of column c, byte 0 at the top of the word.
   always_comb begin
      for (int b = 0; b < 16; b++) begin
         w_in[b] = i_state[127-8*b -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_shift[4*c+r] = w_in[4*((c - r + 4) % 4) + r];
         end
      end
      for (int b = 0; b < 16; b++) begin
         w_keyed[b] = inv_sbox(w_shift[b]) ^ i_roundKey[127-8*b -: 8];
      end
   end

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         w_mix[4*c+0] = gf_mul(8'h0e, w_keyed[4*c]) ^ gf_mul(8'h0b, w_keyed[4*c+1])
                      ^ gf_mul(8'h0d, w_keyed[4*c+2]) ^ gf_mul(8'h09, w_keyed[4*c+3]);
         w_mix[4*c+1] = gf_mul(8'h09, w_keyed[4*c]) ^ gf_mul(8'h0e, w_keyed[4*c+1])
                      ^ gf_mul(8'h0b, w_keyed[4*c+2]) ^ gf_mul(8'h0d, w_keyed[4*c+3]);
         w_mix[4*c+2] = gf_mul(8'h0d, w_keyed[4*c]) ^ gf_mul(8'h09, w_keyed[4*c+1])
                      ^ gf_mul(8'h0e, w_keyed[4*c+2]) ^ gf_mul(8'h0b, w_keyed[4*c+3]);
         w_mix[4*c+3] = gf_mul(8'h0b, w_keyed[4*c]) ^ gf_mul(8'h0d, w_keyed[4*c+1])
                      ^ gf_mul(8'h09, w_keyed[4*c+2]) ^ gf_mul(8'h0e, w_keyed[4*c+3]);
      end
   end

   always_comb begin
      w_keyedFlat = '0;
      w_mixFlat   = '0;
      for (int b = 0; b < 16; b++) begin
         w_keyedFlat[127-8*b -: 8] = w_keyed[b];
         w_mixFlat[127-8*b -: 8]   = w_mix[b];
      end
      if (i_isFirst)     o_nextState = i_state ^ i_roundKey;
      else if (i_isLast) o_nextState = w_keyedFlat;
      else               o_nextState = w_mixFlat;
   end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: expands the key schedule one word per clock into a local
// store (cached for reuse), then runs one inverse round per clock.
module aes_decrypt_iter
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
)(
   input  logic               clk,
   input  logic               rst,
   aes_decrypt_iter_if.slave  bus
);

   localparam int NUM_WORDS = Nb * (Nr + 1);
   localparam int WIDX_W    = $clog2(NUM_WORDS);
   localparam int RND_W     = $clog2(Nr + 1);
   localparam logic [WIDX_W-1:0] FIRST_EXP  = WIDX_W'(Nk);
   localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(NUM_WORDS - 1);
   localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(Nr);
   localparam logic [2:0]        MOD_LAST   = 3'(Nk - 1);

   fsmState_t r_fsm;
   fsmState_t w_fsmNext;

   logic [31:0]        r_w [NUM_WORDS];
   logic [127:0]       r_state;
   logic               r_cacheValid;
   logic [WIDX_W-1:0]  r_wordIdx;
   logic [2:0]         r_wordMod;
   logic [3:0]         r_rconIdx;
   logic [RND_W-1:0]   r_round;

   logic               w_expand;
   logic [WIDX_W-1:0]  w_idxBack;
   logic [WIDX_W-1:0]  w_idxPrev;
   logic [WIDX_W-1:0]  w_rkBase;
   logic [31:0]        w_wordBack;
   logic [31:0]        w_wordPrev;
   logic [31:0]        w_mixWord;
   logic [31:0]        w_newWord;
   logic [127:0]       w_roundKey;
   logic [127:0]       w_nextState;
   logic               w_isFirst;
   logic               w_isLast;

   // A reuse request without a valid cached schedule still has to expand.
   assign w_expand  = bus.new_key || !r_cacheValid;
   assign w_isFirst = (r_round == LAST_ROUND);
   assign w_isLast  = (r_round == '0);

   always_ff @(posedge clk) begin
      if (rst) r_fsm <= IDLE;
      else     r_fsm <= w_fsmNext;
   end

   always_comb begin
      w_fsmNext = r_fsm;
      case (r_fsm)
         IDLE:    if (bus.in_valid) w_fsmNext = w_expand ? EXPAND : ROUND;
         EXPAND:  if (r_wordIdx == LAST_WORD) w_fsmNext = ROUND;
         ROUND:   if (w_isLast) w_fsmNext = DONE;
         DONE:    if (bus.out_ready) w_fsmNext = IDLE;
         default: w_fsmNext = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (r_fsm)
         IDLE:    bus.in_ready  = 1'b1;
         DONE:    bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.data_out = r_state;

   // Schedule word i depends on w[i-Nk] and w[i-1]; i mod Nk and i/Nk are tracked as counters.
   assign w_idxBack  = r_wordIdx - FIRST_EXP;
   assign w_idxPrev  = r_wordIdx - WIDX_W'(1);
   assign w_wordBack = r_w[w_idxBack];
   assign w_wordPrev = r_w[w_idxPrev];

   always_comb begin
      w_mixWord = w_wordPrev;
      if (r_wordMod == 3'd0)
         w_mixWord = sub_word({w_wordPrev[23:0], w_wordPrev[31:24]}) ^ {rcon(r_rconIdx), 24'h000000};
      else if (Nk == 8 && r_wordMod == 3'd4)
         w_mixWord = sub_word(w_wordPrev);
      w_newWord = w_wordBack ^ w_mixWord;
   end

   assign w_rkBase = WIDX_W'({r_round, 2'b00});

   always_comb begin
      w_roundKey = '0;
      for (int k = 0; k < Nb; k++) begin
         w_roundKey[127-32*k -: 32] = r_w[w_rkBase + WIDX_W'(k)];
      end
   end

   aes_inv_round u_invRound (
      .i_state     (r_state),
      .i_roundKey  (w_roundKey),
      .i_isFirst   (w_isFirst),
      .i_isLast    (w_isLast),
      .o_nextState (w_nextState)
   );

   // The store is not reset; its contents only matter once r_cacheValid says so.
   always_ff @(posedge clk) begin
      if (r_fsm == IDLE && bus.in_valid && w_expand) begin
         for (int k = 0; k < Nk; k++) begin
            r_w[k] <= bus.key[Nk*32-1-32*k -: 32];
         end
      end else if (r_fsm == EXPAND) begin
         r_w[r_wordIdx] <= w_newWord;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= '0;
         r_cacheValid <= 1'b0;
         r_wordIdx    <= '0;
         r_wordMod    <= '0;
         r_rconIdx    <= '0;
         r_round      <= '0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (bus.in_valid) begin
                  r_state <= bus.data_in;
                  if (w_expand) begin
                     r_cacheValid <= 1'b0;
                     r_wordIdx    <= FIRST_EXP;
                     r_wordMod    <= 3'd0;
                     r_rconIdx    <= 4'd1;
                  end else begin
                     r_round <= LAST_ROUND;
                  end
               end
            end
            EXPAND: begin
               r_wordIdx <= r_wordIdx + WIDX_W'(1);
               if (r_wordMod == MOD_LAST) begin
                  r_wordMod <= 3'd0;
                  r_rconIdx <= r_rconIdx + 4'd1;
               end else begin
                  r_wordMod <= r_wordMod + 3'd1;
               end
               if (r_wordIdx == LAST_WORD) begin
                  r_cacheValid <= 1'b1;
                  r_round      <= LAST_ROUND;
               end
            end
            ROUND: begin
               r_state <= w_nextState;
               r_round <= r_round - RND_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter: FIPS-197 vectors for AES-128/192/256, key reuse,
// backpressure and reset abandonment, with output latency checked per block.
module tb_aes_decrypt_iter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   aes_decrypt_iter_if #(.Nk(4)) bus128 ();
   aes_decrypt_iter_if #(.Nk(6)) bus192 ();
   aes_decrypt_iter_if #(.Nk(8)) bus256 ();

   aes_decrypt_iter #(.Nk(4), .Nr(10)) dut128 (.clk(clk), .rst(rst), .bus(bus128));
   aes_decrypt_iter #(.Nk(6), .Nr(12)) dut192 (.clk(clk), .rst(rst), .bus(bus192));
   aes_decrypt_iter #(.Nk(8), .Nr(14)) dut256 (.clk(clk), .rst(rst), .bus(bus256));

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] JUNK   = {128'hdeadbeefcafef00d0badc0de55aa33cc, 128'h0};

   typedef struct {
      int           inst;
      logic [127:0] data;
      int           latency;
   } expect_t;

   expect_t      scoreboard[$];
   int           assertCount = 0;
   int           failCount   = 0;
   int           cyc         = 0;
   int           acceptCyc[3];
   logic         prevOutValid[3];
   logic [127:0] heldData[3];

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic sampleOutputs(input int k, output logic inR, output logic outV, output logic [127:0] dOut);
      case (k)
         0:       begin inR = bus128.in_ready; outV = bus128.out_valid; dOut = bus128.data_out; end
         1:       begin inR = bus192.in_ready; outV = bus192.out_valid; dOut = bus192.data_out; end
         default: begin inR = bus256.in_ready; outV = bus256.out_valid; dOut = bus256.data_out; end
      endcase
   endtask

   task automatic monitorInstance(input int k, input logic rstS, input logic inV, input logic inR,
                                  input logic outV, input logic outR, input logic [127:0] dOut);
      logic mine;
      if (rstS) begin
         prevOutValid[k] = 1'b0;
         return;
      end
      mine = (scoreboard.size() > 0) && (scoreboard[0].inst == k);
      if (inV && inR) acceptCyc[k] = cyc;
      if (!mine) begin
         checkOutput($sformatf("idle_out_valid_%0d", k), {127'b0, outV}, 128'd0);
      end else begin
         if (outV) checkOutput($sformatf("in_ready_in_done_%0d", k), {127'b0, inR}, 128'd0);
         if (outV && !prevOutValid[k]) begin
            checkOutput($sformatf("latency_%0d", k), 128'(cyc - acceptCyc[k] - 1), 128'(scoreboard[0].latency));
            heldData[k] = dOut;
         end else if (outV) begin
            checkOutput($sformatf("held_data_%0d", k), dOut, heldData[k]);
         end
         if (outV && outR) begin
            checkOutput($sformatf("plaintext_%0d", k), dOut, scoreboard[0].data);
            void'(scoreboard.pop_front());
         end
      end
      prevOutValid[k] = outV;
   endtask

   always @(negedge clk) begin
      cyc++;
      monitorInstance(0, rst, bus128.in_valid, bus128.in_ready, bus128.out_valid, bus128.out_ready, bus128.data_out);
      monitorInstance(1, rst, bus192.in_valid, bus192.in_ready, bus192.out_valid, bus192.out_ready, bus192.data_out);
      monitorInstance(2, rst, bus256.in_valid, bus256.in_ready, bus256.out_valid, bus256.out_ready, bus256.data_out);
   end

   task automatic setInValid(input int k, input logic v);
      case (k)
         0:       bus128.in_valid = v;
         1:       bus192.in_valid = v;
         default: bus256.in_valid = v;
      endcase
   endtask

   // Returns just after the accepting clock edge.
   task automatic applyStimulus(input int k, input logic [127:0] ct, input logic [255:0] keyIn,
                                input logic nk, input logic expectOut, input int lat);
      expect_t      e;
      logic         ready;
      logic         outV;
      logic [127:0] dOut;
      int           waited;
      if (expectOut) begin
         e.inst    = k;
         e.data    = PT;
         e.latency = lat;
         scoreboard.push_back(e);
      end
      @(posedge clk); #1;
      case (k)
         0:       begin bus128.data_in = ct; bus128.key = keyIn[255 -: 128]; bus128.new_key = nk; end
         1:       begin bus192.data_in = ct; bus192.key = keyIn[255 -: 192]; bus192.new_key = nk; end
         default: begin bus256.data_in = ct; bus256.key = keyIn;             bus256.new_key = nk; end
      endcase
      setInValid(k, 1'b1);
      ready  = 1'b0;
      waited = 0;
      while (!ready && waited < 200) begin
         @(negedge clk);
         sampleOutputs(k, ready, outV, dOut);
         waited++;
      end
      if (!ready) checkOutput("accept_timeout", {127'b0, ready}, 128'd1);
      @(posedge clk); #1;
      setInValid(k, 1'b0);
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (scoreboard.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_timeout", 128'(scoreboard.size()), 128'd0);
      scoreboard.delete();
   endtask

   task automatic pulseReset(input int cycles);
      logic         inR;
      logic         outV;
      logic [127:0] dOut;
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sampleOutputs(k, inR, outV, dOut);
         checkOutput($sformatf("reset_in_ready_%0d", k), {127'b0, inR}, 128'd1);
         checkOutput($sformatf("reset_out_valid_%0d", k), {127'b0, outV}, 128'd0);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic         inR;
      logic         outV;
      logic [127:0] dOut;
      rst = 1'b1;
      bus128.in_valid = 1'b0; bus128.data_in = '0; bus128.key = '0; bus128.new_key = 1'b0; bus128.out_ready = 1'b1;
      bus192.in_valid = 1'b0; bus192.data_in = '0; bus192.key = '0; bus192.new_key = 1'b0; bus192.out_ready = 1'b1;
      bus256.in_valid = 1'b0; bus256.data_in = '0; bus256.key = '0; bus256.new_key = 1'b0; bus256.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         acceptCyc[k]    = 0;
         prevOutValid[k] = 1'b0;
         heldData[k]     = '0;
      end

      $display("[TB] reset");
      @(posedge clk); #1;
      pulseReset(3);
      for (int k = 0; k < 3; k++) begin
         sampleOutputs(k, inR, outV, dOut);
         checkOutput($sformatf("reset_data_out_%0d", k), dOut, 128'd0);
      end

      $display("[TB] AES-128 with key expansion");
      applyStimulus(0, CT128, KEY128, 1'b1, 1'b1, 51);
      waitDrain(200);

      $display("[TB] AES-128 cached key reuse");
      applyStimulus(0, CT128, JUNK, 1'b0, 1'b1, 11);
      waitDrain(100);

      $display("[TB] AES-192");
      applyStimulus(1, CT192, KEY192, 1'b1, 1'b1, 59);
      waitDrain(200);

      $display("[TB] AES-256");
      applyStimulus(2, CT256, KEY256, 1'b1, 1'b1, 67);
      waitDrain(200);

      $display("[TB] backpressure");
      bus128.out_ready = 1'b0;
      applyStimulus(0, CT128, JUNK, 1'b0, 1'b1, 11);
      for (int n = 0; n < 50 && !bus128.out_valid; n++) @(negedge clk);
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         bus128.data_in  = CT192;
         bus128.new_key  = 1'b1;
         bus128.in_valid = (n >= 5 && n < 8);
      end
      @(posedge clk); #1;
      bus128.out_ready = 1'b1;
      waitDrain(10);
      repeat (70) @(negedge clk);

      $display("[TB] reuse request after reset must expand");
      @(posedge clk); #1;
      pulseReset(1);
      applyStimulus(0, CT128, KEY128, 1'b0, 1'b1, 51);
      waitDrain(200);

      $display("[TB] reset during EXPAND");
      applyStimulus(0, CT128, KEY128, 1'b1, 1'b0, 0);
      repeat (9) @(posedge clk);
      #1;
      pulseReset(1);
      applyStimulus(0, CT128, KEY128, 1'b0, 1'b1, 51);
      waitDrain(200);

      $display("[TB] reset during ROUND at r=5");
      applyStimulus(0, CT128, JUNK, 1'b0, 1'b0, 0);
      repeat (6) @(posedge clk);
      #1;
      pulseReset(1);
      applyStimulus(0, CT128, KEY128, 1'b0, 1'b1, 51);
      waitDrain(200);
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
